// File: rtl/mult_share_arbiter.sv
// Round-robin share of one pipelined unsigned multiplier.
// Ports: clk, rst_n, en, req_valid/ready/a/b (packed per requester),
//        rsp_valid/id/data (tagged product), busy (ops in flight).
module mult_share_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_REQ      = 4,
    parameter int MULT_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [2*DATA_WIDTH-1:0]       rsp_data,
    output logic                          busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = 2 * DATA_WIDTH;

    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         gnt_idx;
    logic                  gnt_found;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] a_sel;
    logic [DATA_WIDTH-1:0] b_sel;
    logic [PW-1:0]         prod;

    logic [MULT_LATENCY-1:0] stg_vld;
    logic [IW-1:0]           stg_id  [MULT_LATENCY];
    logic [PW-1:0]           stg_dat [MULT_LATENCY];

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin : arb
        int j;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_found && req_valid[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(j);
            end
        end
    end

    // rst_n gates ready so nothing looks accepted while in reset.
    assign xfer = gnt_found & en & rst_n;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = xfer && (gnt_idx == IW'(i));
        end
    end

    assign a_sel = req_a[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign b_sel = req_b[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign prod  = PW'(a_sel) * PW'(b_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            if (gnt_idx == IW'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gnt_idx + 1'b1;
            end
        end
    end

    // Product is formed at stage 0; later stages only delay it so the
    // multiplier can be retimed across them. Payload only loads behind a
    // valid, which makes the last stage hold its value between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld <= '0;
            for (int s = 0; s < MULT_LATENCY; s++) begin
                stg_id[s]  <= '0;
                stg_dat[s] <= '0;
            end
        end else begin
            stg_vld[0] <= xfer;
            if (xfer) begin
                stg_id[0]  <= gnt_idx;
                stg_dat[0] <= prod;
            end
            for (int s = 1; s < MULT_LATENCY; s++) begin
                stg_vld[s] <= stg_vld[s-1];
                if (stg_vld[s-1]) begin
                    stg_id[s]  <= stg_id[s-1];
                    stg_dat[s] <= stg_dat[s-1];
                end
            end
        end
    end

    assign rsp_valid = stg_vld[MULT_LATENCY-1];
    assign rsp_id    = stg_id[MULT_LATENCY-1];
    assign rsp_data  = stg_dat[MULT_LATENCY-1];
    assign busy      = |stg_vld;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: queue model checked every cycle
// plus literal expectations for the directed scenarios.
module tb_mult_share_arbiter;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int L  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [2*DW-1:0] rsp_data;
    logic            busy;

    logic [DW-1:0] opa [N];
    logic [DW-1:0] opb [N];

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = opa[i];
            req_b[i*DW +: DW] = opb[i];
        end
    end

    mult_share_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(N), .MULT_LATENCY(L)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] p;
    } ent_t;

    ent_t        q[$];
    int          rr = 0;
    logic [1:0]  hid = '0;
    logic [31:0] hdat = '0;
    int          logid[$];
    logic [31:0] logdat[$];
    int          gnt[$];
    int          ncmp = 0;
    int          nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] log_id(input int k);
        if (k < logid.size()) return 64'(logid[k]);
        return 'x;
    endfunction

    function automatic logic [63:0] log_dat(input int k);
        if (k < logdat.size()) return 64'(logdat[k]);
        return 'x;
    endfunction

    function automatic logic [63:0] gnt_at(input int k);
        if (k < gnt.size()) return 64'(gnt[k]);
        return 'x;
    endfunction

    // Model: grant = first valid from rr with wrap; each grant becomes
    // a response due L cycles later, delivered in acceptance order.
    always @(negedge clk) begin : mon
        logic         ev;
        logic         eb;
        int           gi;
        int           j;
        logic [N-1:0] er;
        if (!rst_n) begin
            q.delete();
            rr   = 0;
            hid  = '0;
            hdat = '0;
            chk("rst_valid", 64'(rsp_valid), 0);
            chk("rst_busy", 64'(busy), 0);
            chk("rst_id", 64'(rsp_id), 0);
            chk("rst_data", 64'(rsp_data), 0);
            chk("rst_ready", 64'(req_ready), 0);
        end else begin
            eb = q.size() > 0;
            ev = eb && (q[0].due == cyc);
            if (ev) begin
                hid  = 2'(q[0].id);
                hdat = q[0].p;
                void'(q.pop_front());
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            chk("busy", 64'(busy), 64'(eb));
            chk("rsp_id", 64'(rsp_id), 64'(hid));
            chk("rsp_data", 64'(rsp_data), 64'(hdat));
            if (rsp_valid) begin
                logid.push_back(int'(rsp_id));
                logdat.push_back(rsp_data);
            end
            gi = -1;
            if (en) begin
                for (int k = 0; k < N; k++) begin
                    j = (rr + k) % N;
                    if (gi < 0 && req_valid[j]) gi = j;
                end
            end
            er = '0;
            if (gi >= 0) er[gi] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(er));
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && req_valid[i]) gnt.push_back(i);
            end
            if (gi >= 0) begin
                q.push_back('{cyc + L, gi,
                    {16'b0, opa[gi]} * {16'b0, opb[gi]}});
                rr = (gi + 1) % N;
            end
        end
    end

    // Present requests until nx transfers happen or budget runs out.
    // refill keeps a requester valid with new operands after a grant.
    task automatic serve(input bit refill, input int nx, input int budget);
        int           cnt;
        int           bud;
        logic [N-1:0] g;
        cnt = 0;
        bud = budget;
        while (cnt < nx && bud > 0) begin
            @(negedge clk);
            g = req_valid & req_ready;
            @(posedge clk);
            #1;
            bud--;
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    cnt++;
                    if (refill) begin
                        opa[i] = opa[i] + 16'd1;
                        opb[i] = opb[i] + 16'd3;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
        chk("serve_xfers", 64'(cnt), 64'(nx));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int li;
    int gs;
    int exp_g[6];
    int exp_i[5];
    logic [31:0] exp_d[5];

    initial begin
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        step(2);
        rst_n = 1'b1;

        // single requester, 3*5
        opa[0] = 16'd3;
        opb[0] = 16'd5;
        li = logid.size();
        req_valid = 4'b0001;
        serve(0, 1, 10);
        step(3);
        chk("t1_count", 64'(logid.size() - li), 1);
        chk("t1_id", log_id(li), 0);
        chk("t1_data", log_dat(li), 64'd15);

        // max operands
        opa[2] = 16'hFFFF;
        opb[2] = 16'hFFFF;
        li = logid.size();
        req_valid = 4'b0100;
        serve(0, 1, 10);
        step(3);
        chk("t2_id", log_id(li), 2);
        chk("t2_data", log_dat(li), 64'hFFFE0001);

        // rotation wrap: rr=3 -> req1 -> rr=2; then {1,3} -> 3,1
        gs = gnt.size();
        opa[1] = 16'd7;
        opb[1] = 16'd9;
        req_valid = 4'b0010;
        serve(0, 1, 10);
        opa[3] = 16'd11;
        opb[3] = 16'd13;
        req_valid = 4'b1010;
        serve(0, 2, 10);
        opa[0] = 16'd2;
        opb[0] = 16'd4;
        opa[2] = 16'd6;
        opb[2] = 16'd8;
        req_valid = 4'b0111;
        serve(0, 3, 10);
        step(3);
        exp_g = '{1, 3, 1, 2, 0, 1};
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3_gnt%0d", k), gnt_at(gs + k), 64'(exp_g[k]));
        end

        // enable gating with two in flight
        li = logid.size();
        req_valid = 4'b1111;
        serve(1, 2, 10);
        en = 1'b0;
        @(negedge clk);
        chk("t4_ready_a", 64'(req_ready), 0);
        chk("t4_busy_a", 64'(busy), 1);
        @(negedge clk);
        chk("t4_busy_b", 64'(busy), 1);
        @(negedge clk);
        chk("t4_busy_c", 64'(busy), 0);
        chk("t4_ready_c", 64'(req_ready), 0);
        chk("t4_count", 64'(logid.size() - li), 2);
        chk("t4_id0", log_id(li), 2);
        chk("t4_id1", log_id(li + 1), 3);
        @(posedge clk);
        #1;
        en = 1'b1;
        serve(0, 4, 10);
        step(3);

        // reset with two in flight, then contention from reset
        req_valid = 4'b1111;
        serve(1, 2, 10);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            opa[i] = 16'(i + 1);
            opb[i] = 16'(10 * (i + 1));
        end
        li = logid.size();
        gs = gnt.size();
        step(1);
        rst_n = 1'b1;
        serve(1, 5, 20);
        req_valid = '0;
        step(4);
        exp_i = '{0, 1, 2, 3, 0};
        exp_d = '{32'd10, 32'd40, 32'd90, 32'd160, 32'd26};
        chk("t5_count", 64'(logid.size() - li), 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t5_gnt%0d", k), gnt_at(gs + k), 64'(exp_i[k]));
            chk($sformatf("t5_id%0d", k), log_id(li + k), 64'(exp_i[k]));
            chk($sformatf("t5_data%0d", k), log_dat(li + k), 64'(exp_d[k]));
        end
        chk("t5_idle", 64'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
